// File: rtl/led_matrix_scan.sv
// led_matrix_scan
//   Double-buffered row-scan driver for an X-column by Y-row LED matrix.
//   The life engine writes pixel rows into the back buffer. The scanner
//   lights one row of the front buffer at a time: BLANK dark clocks, then
//   DWELL lit clocks per row. When a complete frame has been captured
//   (row Y-1 written), the buffers swap at the next frame wrap.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous active-high reset; aborts everything, clears buffers
//   row[Y-1:0] : one-hot row-write strobe, all-zero = idle
//   col[X-1:0] : pixel data for the strobed row
//   led_row    : registered one-hot row drive (zero while blanking)
//   led_col    : registered column drive for the lit row
//   frame_swap : one-cycle pulse when the front buffer changes
//   row_err    : one-cycle pulse, the cycle after a multi-hot row strobe
module led_matrix_scan #(
    parameter int X     = 16,
    parameter int Y     = 16,
    parameter int LOG2Y = 4,
    parameter int DWELL = 64,
    parameter int BLANK = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [Y-1:0] row,
    input  logic [X-1:0] col,
    output logic [Y-1:0] led_row,
    output logic [X-1:0] led_col,
    output logic         frame_swap,
    output logic         row_err
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_SHOW  = 1'b1
    } state_t;

    state_t           state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [LOG2Y-1:0] sidx_reg;
    logic             bank_reg;
    logic             pending_reg;

    // bank_reg = 0: buf0 is front, buf1 is back; bank_reg = 1: the reverse.
    logic [X-1:0]     buf0_reg [Y];
    logic [X-1:0]     buf1_reg [Y];

    logic [Y-1:0]     led_row_reg;
    logic [X-1:0]     led_col_reg;
    logic             frame_swap_reg;
    logic             row_err_reg;

    // Strobe decode
    logic             multi_hot;
    logic             capture;
    logic [LOG2Y-1:0] row_idx;

    // Scan helpers
    logic [Y-1:0]     sidx_onehot;
    logic [X-1:0]     front_row;
    logic             show_last;
    logic             wrap;

    // Clearing the lowest set bit leaves something only if two or more bits are set.
    assign multi_hot = |(row & (row - Y'(1)));
    assign capture   = (|row) && !multi_hot;

    always_comb begin
        row_idx = '0;
        for (int i = 0; i < Y; i++) begin
            if (row[i]) begin
                row_idx = LOG2Y'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < Y; gi++) begin : g_sidx_dec
            assign sidx_onehot[gi] = (sidx_reg == LOG2Y'(gi));
        end
    endgenerate

    assign front_row = bank_reg ? buf1_reg[sidx_reg] : buf0_reg[sidx_reg];
    assign show_last = (state_reg == S_SHOW) && (cnt_reg == CW'(DWELL - 1));
    // Wrap: the last lit clock of the last row, where sidx rolls back to 0.
    assign wrap      = show_last && (sidx_reg == LOG2Y'(Y - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_BLANK;
            cnt_reg        <= '0;
            sidx_reg       <= '0;
            bank_reg       <= 1'b0;
            pending_reg    <= 1'b0;
            led_row_reg    <= '0;
            led_col_reg    <= '0;
            frame_swap_reg <= 1'b0;
            row_err_reg    <= 1'b0;
            for (int i = 0; i < Y; i++) begin
                buf0_reg[i] <= '0;
                buf1_reg[i] <= '0;
            end
        end else begin
            row_err_reg    <= multi_hot;
            frame_swap_reg <= 1'b0;

            // Captures always land in the back buffer.
            if (capture) begin
                if (bank_reg) begin
                    buf0_reg[row_idx] <= col;
                end else begin
                    buf1_reg[row_idx] <= col;
                end
            end

            // Outputs follow the state one register stage later; row and
            // column data are updated together.
            if (state_reg == S_SHOW) begin
                led_row_reg <= sidx_onehot;
                led_col_reg <= front_row;
            end else begin
                led_row_reg <= '0;
                led_col_reg <= '0;
            end

            case (state_reg)
                S_BLANK: begin
                    if (cnt_reg == CW'(BLANK - 1)) begin
                        state_reg <= S_SHOW;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (show_last) begin
                        state_reg <= S_BLANK;
                        cnt_reg   <= '0;
                        if (sidx_reg == LOG2Y'(Y - 1)) begin
                            sidx_reg <= '0;
                        end else begin
                            sidx_reg <= sidx_reg + LOG2Y'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    state_reg <= S_BLANK;
                    cnt_reg   <= '0;
                end
            endcase

            // A capture landing on the wrap cycle defers the swap by one
            // frame so a half-written row is never shown.
            if (wrap && pending_reg && !capture) begin
                bank_reg       <= ~bank_reg;
                pending_reg    <= 1'b0;
                frame_swap_reg <= 1'b1;
            end else if (capture && (row_idx == LOG2Y'(Y - 1))) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign led_row    = led_row_reg;
    assign led_col    = led_col_reg;
    assign frame_swap = frame_swap_reg;
    assign row_err    = row_err_reg;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Testbench for led_matrix_scan with X=Y=16, DWELL=8, BLANK=2 (160-clock frame).
// Inputs are driven and outputs sampled on the falling edge. cyc counts
// rising edges since reset was released. The display is checked every cycle
// against the frame timing and a bench copy of the front buffer. Expected
// frame_swap and row_err pulses are queued by the scenario tasks when they
// drive the stimulus and popped when the cycle arrives.
module tb_led_matrix_scan;

    localparam int X      = 16;
    localparam int Y      = 16;
    localparam int DWELL  = 8;
    localparam int BLANK  = 2;
    localparam int ROWP   = DWELL + BLANK;
    localparam int FRAME  = Y * ROWP;

    logic          clk;
    logic          reset;
    logic [Y-1:0]  row;
    logic [X-1:0]  col;
    logic [Y-1:0]  led_row;
    logic [X-1:0]  led_col;
    logic          frame_swap;
    logic          row_err;

    int            checks;
    int            errors;
    int            cyc;

    logic [X-1:0]  exp_front [Y];
    logic [X-1:0]  exp_back  [Y];
    int            swap_q[$];
    int            err_q[$];

    led_matrix_scan #(
        .X     (X),
        .Y     (Y),
        .LOG2Y (4),
        .DWELL (DWELL),
        .BLANK (BLANK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .led_row    (led_row),
        .led_col    (led_col),
        .frame_swap (frame_swap),
        .row_err    (row_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int next_wrap(input int w);
        return (w / FRAME + 1) * FRAME;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < Y; i++) begin
            exp_front[i] = '0;
            exp_back[i]  = '0;
        end
        swap_q.delete();
        err_q.delete();
    endtask

    // Advance one clock and score the cycle just produced.
    task automatic advance();
        int           m;
        int           r;
        int           ph;
        logic [Y-1:0] exp_row;
        logic [X-1:0] exp_col;
        logic         exp_fs;
        logic         exp_err;
        logic [X-1:0] t;
        @(negedge clk);
        if (reset) begin
            cyc = 0;
            checks++;
            if (led_row !== '0 || led_col !== '0 || frame_swap !== 1'b0 || row_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got row=%h col=%h fs=%b err=%b, required all 0",
                         led_row, led_col, frame_swap, row_err);
            end
        end else begin
            cyc++;
            m  = (cyc - 1) % FRAME;
            r  = m / ROWP;
            ph = m % ROWP;
            exp_row = (ph >= BLANK) ? (Y'(1) << r) : '0;
            exp_col = (ph >= BLANK) ? exp_front[r] : '0;
            checks++;
            if (led_row !== exp_row) begin
                errors++;
                $display("FAIL led_row cyc=%0d: got %h, required %h", cyc, led_row, exp_row);
            end
            checks++;
            if (led_col !== exp_col) begin
                errors++;
                $display("FAIL led_col cyc=%0d: got %h, required %h", cyc, led_col, exp_col);
            end
            exp_fs = (swap_q.size() > 0) && (swap_q[0] == cyc);
            checks++;
            if (frame_swap !== exp_fs) begin
                errors++;
                $display("FAIL frame_swap cyc=%0d: got %b, required %b", cyc, frame_swap, exp_fs);
            end
            if (exp_fs) begin
                void'(swap_q.pop_front());
                for (int i = 0; i < Y; i++) begin
                    t            = exp_front[i];
                    exp_front[i] = exp_back[i];
                    exp_back[i]  = t;
                end
                $display("swap at cyc %0d", cyc);
            end
            exp_err = (err_q.size() > 0) && (err_q[0] == cyc);
            checks++;
            if (row_err !== exp_err) begin
                errors++;
                $display("FAIL row_err cyc=%0d: got %b, required %b", cyc, row_err, exp_err);
            end
            if (exp_err) begin
                void'(err_q.pop_front());
            end
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) advance();
    endtask

    // One-clock capture strobe; the write lands on edge cyc+1.
    task automatic write_row(input int idx, input logic [X-1:0] c);
        row = Y'(1) << idx;
        col = c;
        advance();
        exp_back[idx] = c;
        $display("write row %0d col %h at cyc %0d", idx, c, cyc);
        row = '0;
        col = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        row   = '0;
        col   = '0;
        repeat (3) advance();
        checks++;
        if (led_row !== '0 || led_col !== '0) begin
            errors++;
            $display("FAIL test_reset: got row=%h col=%h, required 0/0", led_row, led_col);
        end
        clear_model();
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_idle_scan();
        wait_until(400);
        $display("idle scan done at cyc %0d", cyc);
    endtask

    task automatic test_capture();
        logic [X-1:0] c;
        for (int i = 0; i < Y; i++) begin
            c = (i == 7 || i == 9) ? 16'h0100 : ((i == 8) ? 16'h0380 : 16'h0000);
            write_row(i, c);
        end
        swap_q.push_back(next_wrap(cyc));
        wait_until(800);
    endtask

    task automatic test_row_err();
        row = 16'h0003;
        col = 16'hFFFF;
        err_q.push_back(cyc + 1);
        advance();
        $display("multi-hot row %h at cyc %0d", row, cyc);
        row = '0;
        col = '0;
        checks++;
        if (row_err !== 1'b1) begin
            errors++;
            $display("FAIL test_row_err pulse: got %b, required 1", row_err);
        end
        write_row(15, 16'h8001);
        swap_q.push_back(next_wrap(cyc));
        wait_until(1099);
    endtask

    task automatic test_wrap_collision();
        write_row(15, 16'h0FF0);
        write_row(3, 16'h00C3);
        wait_until(FRAME * 7 - 1);
        write_row(15, 16'h1234);
        checks++;
        if (frame_swap !== 1'b0) begin
            errors++;
            $display("FAIL test_wrap_collision: got frame_swap=%b on wrap, required 0", frame_swap);
        end
        swap_q.push_back(next_wrap(cyc));
        wait_until(1300);
    endtask

    task automatic test_reset_mid();
        write_row(15, 16'hFFFF);
        wait_until(1305);
        reset = 1'b1;
        advance();
        checks++;
        if (led_row !== '0 || led_col !== '0 || frame_swap !== 1'b0) begin
            errors++;
            $display("FAIL test_reset_mid: got row=%h col=%h fs=%b, required 0",
                     led_row, led_col, frame_swap);
        end
        clear_model();
        reset = 1'b0;
        $display("mid-frame reset released");
        wait_until(400);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < Y; i++) begin
            write_row(i, 16'(i * 16'h0101));
        end
        for (int i = 0; i < Y; i++) begin
            write_row(i, 16'hFFFF ^ 16'(i * 3));
        end
        swap_q.push_back(next_wrap(cyc));
        wait_until(660);
        checks++;
        if (swap_q.size() != 0) begin
            errors++;
            $display("FAIL test_back_to_back: got %0d swaps outstanding, required 0", swap_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        reset  = 1'b1;
        row    = '0;
        col    = '0;
        test_reset();
        test_idle_scan();
        test_capture();
        test_row_err();
        test_wrap_collision();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
